register_file_mp: RTL and testbench

Parametrised multi-port integer register file for the Grande-Risco-5 core: configurable XLEN, register count (RV32I/RV32E), read-port and write-port count, with x0 hardwired to zero. A post-reset clear sequencer zeroes the array one entry per cycle, keeping it inferable as distributed RAM. A request/acknowledge debug port serves the JTAG/debug module and never collides with core writes. It replaces the single-write, two-read register file in the decode/writeback path.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_dbg_port.sv | 48 ++++
 rtl/register_file_mp.sv | 112 +++++++++++
 tb/tb_register_file_mp.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: clear-sequencer and debug-port
// state encodings, plus the address-width helper.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_e;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dbg_state_e;

    // Register index width; never below one bit so tiny configs still elaborate.
    function automatic int regfile_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug request/acknowledge port: grant logic, two-state handshake FSM and
// capture of the read-back / echoed write data.
module regfile_dbg_port
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busy,
    input  logic            core_wr_active,
    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    input  logic [XLEN-1:0] entry_rdata,
    output logic            dbg_grant,
    output logic            dbg_ack_o,
    output logic [XLEN-1:0] dbg_rdata_o
);

    dbg_state_e state;

    // Handshake: dbg_req_i is held until dbg_ack_o; a grant needs an idle FSM,
    // a finished clear and no core write this cycle (core always has priority).
    always_comb begin
        dbg_grant = (state == D_IDLE) && dbg_req_i && !busy && !core_wr_active && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= D_IDLE;
            dbg_rdata_o <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (dbg_grant) begin
                        state       <= D_ACK;
                        dbg_rdata_o <= dbg_we_i ? dbg_wdata_i : entry_rdata;
                    end
                end
                default: state <= D_IDLE;
            endcase
        end
    end

    assign dbg_ack_o = (state == D_ACK);

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with x0 hardwired to zero, post-reset clear
// sequencer and debug port. Define REGFILE_BYPASS_EN for same-cycle write bypass.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int NREGS        = 32,
    parameter  int NUM_RD_PORTS = 2,
    parameter  int NUM_WR_PORTS = 1,
    localparam int AW           = regfile_aw(NREGS)
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                busy_o,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]     rd_addr_i,
    output logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rd_data_o,
    input  logic [NUM_WR_PORTS-1:0]             wr_en_i,
    input  logic [NUM_WR_PORTS-1:0][AW-1:0]     wr_addr_i,
    input  logic [NUM_WR_PORTS-1:0][XLEN-1:0]   wr_data_i,
    input  logic                                dbg_req_i,
    input  logic                                dbg_we_i,
    input  logic [AW-1:0]                       dbg_addr_i,
    input  logic [XLEN-1:0]                     dbg_wdata_i,
    output logic                                dbg_ack_o,
    output logic [XLEN-1:0]                     dbg_rdata_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0]         regs [NREGS];
    clr_state_e              clr_state;
    logic [AW-1:0]           clr_cnt;
    logic                    clr_we;
    logic [NUM_WR_PORTS-1:0] core_we;
    logic                    dbg_grant;
    logic                    dbg_wr;
    logic [XLEN-1:0]         dbg_entry;

    // Entry 0 is never stored, so the clear walks 1..NREGS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_state <= CLEAR;
            clr_cnt   <= AW'(1);
        end else if (clr_state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == LAST_IDX) begin
                clr_state <= RUN;
            end
        end
    end

    assign busy_o = (clr_state == CLEAR);
    assign clr_we = busy_o && !rst;

    always_comb begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            core_we[p] = wr_en_i[p] && !busy_o && (wr_addr_i[p] != '0);
        end
    end

    assign dbg_wr    = dbg_grant && dbg_we_i && (dbg_addr_i != '0);
    assign dbg_entry = (dbg_addr_i == '0) ? '0 : regs[dbg_addr_i];

    // Clear, core and debug writes are mutually exclusive by construction;
    // among core ports the later loop iteration (higher index) wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_cnt] <= '0;
        end
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (core_we[p]) begin
                regs[wr_addr_i[p]] <= wr_data_i[p];
            end
        end
        if (dbg_wr) begin
            regs[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
            rd_data_o[r] = '0;
            if (!busy_o && (rd_addr_i[r] != '0)) begin
                rd_data_o[r] = regs[rd_addr_i[r]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR_PORTS; w++) begin
                    if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[r])) begin
                        rd_data_o[r] = wr_data_i[w];
                    end
                end
`endif
            end
        end
    end

    regfile_dbg_port #(
        .XLEN (XLEN)
    ) u_dbg_port (
        .clk            (clk),
        .rst            (rst),
        .busy           (busy_o),
        .core_wr_active (|wr_en_i),
        .dbg_req_i      (dbg_req_i),
        .dbg_we_i       (dbg_we_i),
        .dbg_wdata_i    (dbg_wdata_i),
        .entry_rdata    (dbg_entry),
        .dbg_grant      (dbg_grant),
        .dbg_ack_o      (dbg_ack_o),
        .dbg_rdata_o    (dbg_rdata_o)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (32 regs, 2 read, 2 write ports).
module tb_register_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     busy;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     dbg_req;
    logic                     dbg_we;
    logic [AW-1:0]            dbg_addr;
    logic [XLEN-1:0]          dbg_wdata;
    logic                     dbg_ack;
    logic [XLEN-1:0]          dbg_rdata;

    register_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR)
    ) dut (
        .clk(clk), .rst(rst), .busy_o(busy),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [XLEN-1:0] mdl [NREGS];
    int              clear_left = NREGS - 1;
    logic [XLEN-1:0] exp_q [$];

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0, wa1;
        logic [XLEN-1:0] wd0, wd1;
        logic [AW-1:0]   ra0, ra1;
        logic [XLEN-1:0] e0, e1;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] e;
        if (clear_left > 0 || a == 0) return '0;
        e = mdl[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p] == a) e = wr_data[p];
`endif
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Model absorbs what the coming edge will sample, then the edge happens.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mdl[i] = '0;
            clear_left = NREGS - 1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p] != 0) mdl[wr_addr[p]] = wr_data[p];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; wr_en = '0; dbg_req = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // Counts busy cycles while hammering core writes that must be ignored.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin
            wr_en = 2'b11;
            wr_addr[0] = AW'($urandom_range(NREGS-1, 1));
            wr_addr[1] = AW'($urandom_range(NREGS-1, 1));
            wr_data[0] = $urandom;
            wr_data[1] = $urandom;
            rd_addr[0] = AW'($urandom_range(NREGS-1, 1));
            settle();
            check({name, "_rd_zero"}, rd_data[0], '0);
            n++;
            step();
            wr_en = '0;
        end
        check({name, "_busy_len"}, 32'(n), 32'(NREGS - 1));
    endtask

    task automatic dbg_access(input logic we, input logic [AW-1:0] addr, input logic [XLEN-1:0] wdata,
                              output logic [XLEN-1:0] rdata, output int lat);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; lat = 0;
        do begin
            step();
            lat++;
        end while (!dbg_ack && lat < 20);
        if (!dbg_ack) begin
            n_checks++; n_fail++;
            $display("FAIL dbg_timeout: no ack for addr %0d after %0d cycles", addr, lat);
        end else if (we && addr != 0) begin
            mdl[addr] = wdata;
        end
        rdata = dbg_rdata;
        dbg_req = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [XLEN-1:0] rd;
        logic [XLEN-1:0] e;
        int              lat;

        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        vecs[0] = '{2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 5'd3, 5'd4, 32'h0, 32'h0};
        vecs[1] = '{2'b01, 5'd3, 5'd0, 32'h33333333, 32'h0,        5'd1, 5'd2, 32'h11111111, 32'h22222222};
        vecs[2] = '{2'b11, 5'd0, 5'd4, 32'hFFFFFFFF, 32'h44444444, 5'd3, 5'd0, 32'h33333333, 32'h0};
        vecs[3] = '{2'b11, 5'd5, 5'd5, 32'hAAAA0000, 32'h12345678, 5'd4, 5'd0, 32'h44444444, 32'h0};
        vecs[4] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd5, 5'd1, 32'h12345678, 32'h11111111};
        vecs[5] = '{2'b01, 5'd1, 5'd0, 32'h0,        32'h0,        5'd2, 5'd3, 32'h22222222, 32'h33333333};
        vecs[6] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd1, 5'd5, 32'h0,        32'h12345678};

        // Reset values and clear duration.
        do_reset(2);
        check("reset_busy", busy, 1);
        check("reset_ack", dbg_ack, 0);
        check("reset_rdata", dbg_rdata, '0);
        count_busy("clear");

        // Every entry reads zero through the debug port; minimum latency is 1.
        for (int a = 0; a < NREGS; a++) begin
            dbg_access(1'b0, AW'(a), $urandom, rd, lat);
            check("clear_dbg_read", rd, '0);
            if (a == 1) check("dbg_min_latency", 32'(lat), 32'd1);
            step();
        end

        // Table vectors: writes, collisions, x0 discard.
        for (int i = 0; i < 7; i++) begin
            wr_en = vecs[i].we;
            wr_addr[0] = vecs[i].wa0; wr_addr[1] = vecs[i].wa1;
            wr_data[0] = vecs[i].wd0; wr_data[1] = vecs[i].wd1;
            rd_addr[0] = vecs[i].ra0; rd_addr[1] = vecs[i].ra1;
            settle();
            check("vec_rd0", rd_data[0], vecs[i].e0);
            check("vec_rd1", rd_data[1], vecs[i].e1);
            step();
        end
        wr_en = '0;

        // Same-cycle bypass on x7.
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h01020304;
        step();
        wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd7;
        settle();
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rd_data[0], 32'hDEADBEEF);
`else
        check("bypass_same_cycle", rd_data[0], 32'h01020304);
`endif
        step();
        wr_en = '0;
        settle();
        check("bypass_next_cycle", rd_data[0], 32'hDEADBEEF);

        // Debug read of x3 held off by 3 cycles of core writes.
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h0BADCAFE;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        wr_addr[0] = 5'd9;
        for (int i = 0; i < 3; i++) begin
            wr_data[0] = $urandom;
            step();
            if (i == 2) wr_en = '0;
            check("dbg_blocked_ack", dbg_ack, 0);
        end
        step();
        check("dbg_after_idle_ack", dbg_ack, 1);
        check("dbg_after_idle_data", dbg_rdata, 32'h0BADCAFE);
        dbg_req = 1'b0;
        step();
        check("dbg_ack_drops", dbg_ack, 0);

        // Debug write to x10 visible from the ack cycle.
        dbg_access(1'b1, 5'd10, 32'hCAFEF00D, rd, lat);
        rd_addr[0] = 5'd10;
        settle();
        check("dbgwr_rdata", rd, 32'hCAFEF00D);
        check("dbgwr_core_read_ack", rd_data[0], 32'hCAFEF00D);
        step();
        check("dbgwr_ack_one_cycle", dbg_ack, 0);
        check("dbgwr_core_read_after", rd_data[0], 32'hCAFEF00D);

        // Randomised traffic against the model via the expected queue.
        for (int c = 0; c < 300; c++) begin
            if (c % 50 == 49) begin
                wr_en = '0;
                dbg_addr = AW'($urandom_range(NREGS-1, 0));
                e = (dbg_addr == 0) ? '0 : mdl[dbg_addr];
                dbg_access(1'b0, dbg_addr, '0, rd, lat);
                check("rand_dbg_read", rd, e);
                step();
            end
            wr_en = 2'($urandom_range(3, 0));
            for (int p = 0; p < NWR; p++) begin
                wr_addr[p] = AW'($urandom_range(NREGS-1, 0));
                wr_data[p] = $urandom;
            end
            for (int r = 0; r < NRD; r++) begin
                rd_addr[r] = (($urandom_range(3, 0) == 0) && wr_en[0]) ? wr_addr[0] : AW'($urandom_range(NREGS-1, 0));
                exp_q.push_back(exp_read(rd_addr[r]));
            end
            settle();
            for (int r = 0; r < NRD; r++) check("rand_read", rd_data[r], exp_q.pop_front());
            step();
        end
        wr_en = '0;

        // Reset in the D_ACK cycle drops the ack and restarts the clear.
        dbg_access(1'b0, 5'd3, '0, rd, lat);
        check("rst_mid_ack_seen", dbg_ack, 1);
        rst = 1'b1;
        step();
        check("rst_mid_ack", dbg_ack, 0);
        check("rst_mid_busy", busy, 1);
        check("rst_mid_rdata", dbg_rdata, '0);
        rst = 1'b0;
        count_busy("reclear");
        dbg_access(1'b0, 5'd3, '0, rd, lat);
        check("reclear_x3", rd, '0);
        step();
        dbg_access(1'b0, 5'd1, '0, rd, lat);
        check("reclear_x1", rd, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
